// File: rtl/node_interface.sv
// node_interface: node-side end of the mesh valid/enable links, with a TX FIFO (core -> router port 0)
// and an RX FIFO (router port 0 -> core). Optional transfer counters under `NODE_INTERFACE_STATS_EN.

`ifndef X_NODES
`define X_NODES 4
`endif
`ifndef Y_NODES
`define Y_NODES 4
`endif

package node_interface_pkg;
  localparam int unsigned PACKET_W = 32;
  typedef logic [PACKET_W-1:0] packet_t;
endpackage

// Circular-buffer FIFO with valid/enable on both sides; all outputs derive from registered state.
module node_interface_fifo
  import node_interface_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset_n,
  input  packet_t push_data,
  input  logic    push_val,
  output logic    push_en,
  output packet_t pop_data,
  output logic    pop_val,
  input  logic    pop_en
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("node_interface_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  packet_t          mem [DEPTH];
  logic             push;
  logic             pop;

  assign push_en  = (count != CNT_W'(DEPTH));
  assign pop_val  = (count != '0);
  assign pop_data = pop_val ? mem[rd_ptr] : '0;
  assign push     = push_val && push_en;
  assign pop      = pop_val && pop_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: stale entries are unreachable once the pointers and count clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

module node_interface
  import node_interface_pkg::*;
#(
  parameter int unsigned X_NODES  = `X_NODES,
  parameter int unsigned Y_NODES  = `Y_NODES,
  parameter int unsigned NODE_ID  = 0,
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  packet_t     i_core_data,
  input  logic        i_core_data_val,
  output logic        o_core_en,
  output packet_t     o_net_data,
  output logic        o_net_data_val,
  input  logic        i_net_en,
  input  packet_t     i_net_data,
  input  logic        i_net_data_val,
  output logic        o_net_en,
  output packet_t     o_core_data,
  output logic        o_core_data_val,
  input  logic        i_core_en,
  output logic [31:0] o_tx_count,
  output logic [31:0] o_rx_count
);

  if (NODE_ID >= X_NODES * Y_NODES) begin : g_bad_node_id
    $error("node_interface: NODE_ID outside 0..X_NODES*Y_NODES-1");
  end

  node_interface_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push_data (i_core_data),
    .push_val  (i_core_data_val),
    .push_en   (o_core_en),
    .pop_data  (o_net_data),
    .pop_val   (o_net_data_val),
    .pop_en    (i_net_en)
  );

  node_interface_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push_data (i_net_data),
    .push_val  (i_net_data_val),
    .push_en   (o_net_en),
    .pop_data  (o_core_data),
    .pop_val   (o_core_data_val),
    .pop_en    (i_core_en)
  );

`ifdef NODE_INTERFACE_STATS_EN
  logic [31:0] tx_count;
  logic [31:0] rx_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_count <= '0;
      rx_count <= '0;
    end else begin
      if (o_net_data_val && i_net_en)   tx_count <= tx_count + 32'd1;
      if (o_core_data_val && i_core_en) rx_count <= rx_count + 32'd1;
    end
  end

  assign o_tx_count = tx_count;
  assign o_rx_count = rx_count;
`else
  assign o_tx_count = '0;
  assign o_rx_count = '0;
`endif

endmodule

// File: tb/tb_node_interface.sv
// Directed self-checking bench for node_interface (TX_DEPTH = RX_DEPTH = 4).
module tb_node_interface;
  import node_interface_pkg::*;

  logic        clk;
  logic        reset_n;
  packet_t     i_core_data;
  logic        i_core_data_val;
  logic        o_core_en;
  packet_t     o_net_data;
  logic        o_net_data_val;
  logic        i_net_en;
  packet_t     i_net_data;
  logic        i_net_data_val;
  logic        o_net_en;
  packet_t     o_core_data;
  logic        o_core_data_val;
  logic        i_core_en;
  logic [31:0] o_tx_count;
  logic [31:0] o_rx_count;

  int checks = 0;
  int errors = 0;

  node_interface #(.NODE_ID(0), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_core_data     (i_core_data),
    .i_core_data_val (i_core_data_val),
    .o_core_en       (o_core_en),
    .o_net_data      (o_net_data),
    .o_net_data_val  (o_net_data_val),
    .i_net_en        (i_net_en),
    .i_net_data      (i_net_data),
    .i_net_data_val  (i_net_data_val),
    .o_net_en        (o_net_en),
    .o_core_data     (o_core_data),
    .o_core_data_val (o_core_data_val),
    .i_core_en       (i_core_en),
    .o_tx_count      (o_tx_count),
    .o_rx_count      (o_rx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    i_core_data     = '0;
    i_core_data_val = 1'b0;
    i_net_en        = 1'b0;
    i_net_data      = '0;
    i_net_data_val  = 1'b0;
    i_core_en       = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    checks++; if (o_core_en !== 1'b1) begin errors++; $display("FAIL reset_core_en: got %b expected 1", o_core_en); end
    checks++; if (o_net_en !== 1'b1) begin errors++; $display("FAIL reset_net_en: got %b expected 1", o_net_en); end
    checks++; if (o_net_data_val !== 1'b0) begin errors++; $display("FAIL reset_net_val: got %b expected 0", o_net_data_val); end
    checks++; if (o_core_data_val !== 1'b0) begin errors++; $display("FAIL reset_core_val: got %b expected 0", o_core_data_val); end
    checks++; if (o_net_data !== 32'h0) begin errors++; $display("FAIL reset_net_data: got %h expected 0", o_net_data); end
    checks++; if (o_core_data !== 32'h0) begin errors++; $display("FAIL reset_core_data: got %h expected 0", o_core_data); end
    checks++; if (o_tx_count !== 32'h0) begin errors++; $display("FAIL reset_tx_count: got %0d expected 0", o_tx_count); end
    checks++; if (o_rx_count !== 32'h0) begin errors++; $display("FAIL reset_rx_count: got %0d expected 0", o_rx_count); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_latency;
    idle_inputs();
    i_net_en        = 1'b1;
    i_core_data     = 32'h55;
    i_core_data_val = 1'b1;
    checks++; if (o_net_data_val !== 1'b0) begin errors++; $display("FAIL lat_pre_val: got %b expected 0", o_net_data_val); end
    tick();
    i_core_data_val = 1'b0;
    i_core_data     = '0;
    checks++; if (o_net_data_val !== 1'b1) begin errors++; $display("FAIL lat_val: got %b expected 1", o_net_data_val); end
    checks++; if (o_net_data !== 32'h55) begin errors++; $display("FAIL lat_data: got %h expected 55", o_net_data); end
    tick();
    checks++; if (o_net_data_val !== 1'b0) begin errors++; $display("FAIL lat_drained_val: got %b expected 0", o_net_data_val); end
    checks++; if (o_net_data !== 32'h0) begin errors++; $display("FAIL lat_empty_data: got %h expected 0", o_net_data); end
  endtask

  task automatic test_tx_fill;
    packet_t pk [5];
    int in_i = 0;
    int out_i = 0;
    int first = -1;
    int last = -1;
    logic acc_in, acc_out;
    pk[0] = 32'hA0A0_0001; pk[1] = 32'hB0B0_0002; pk[2] = 32'hC0C0_0003;
    pk[3] = 32'hD0D0_0004; pk[4] = 32'hE0E0_0005;
    idle_inputs();
    for (int cyc = 0; cyc < 20 && out_i < 5; cyc++) begin
      i_net_en        = (cyc >= 5);
      i_core_data_val = (in_i < 5);
      i_core_data     = (in_i < 5) ? pk[in_i] : '0;
      if (cyc == 2) begin
        checks++; if (o_core_en !== 1'b1) begin errors++; $display("FAIL fill_en_before_d: got %b expected 1", o_core_en); end
      end
      if (cyc == 4) begin
        checks++; if (o_core_en !== 1'b0) begin errors++; $display("FAIL fill_en_full: got %b expected 0", o_core_en); end
        checks++; if (in_i !== 4) begin errors++; $display("FAIL fill_accepted: got %0d expected 4", in_i); end
        checks++; if (o_net_data !== pk[0]) begin errors++; $display("FAIL fill_head: got %h expected %h", o_net_data, pk[0]); end
      end
      acc_in  = i_core_data_val && o_core_en;
      acc_out = o_net_data_val && i_net_en;
      if (acc_out) begin
        checks++;
        if (out_i < 5 && o_net_data !== pk[out_i]) begin
          errors++; $display("FAIL fill_order[%0d]: got %h expected %h", out_i, o_net_data, pk[out_i]);
        end
        if (first < 0) first = cyc;
        last = cyc;
      end
      tick();
      if (acc_in) in_i++;
      if (acc_out) out_i++;
    end
    idle_inputs();
    checks++; if (out_i !== 5) begin errors++; $display("FAIL fill_count: got %0d expected 5", out_i); end
    checks++; if (first !== 5 || last !== 9) begin errors++; $display("FAIL fill_consecutive: got %0d..%0d expected 5..9", first, last); end
    checks++; if (o_net_data_val !== 1'b0) begin errors++; $display("FAIL fill_drained: got %b expected 0", o_net_data_val); end
  endtask

  task automatic test_simul_push_pop;
    packet_t q [$];
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      i_net_data     = 32'h100 + k;
      i_net_data_val = 1'b1;
      q.push_back(32'h100 + k);
      tick();
    end
    for (int cyc = 0; cyc < 10; cyc++) begin
      i_net_data     = 32'h102 + cyc;
      i_net_data_val = 1'b1;
      i_core_en      = 1'b1;
      q.push_back(32'h102 + cyc);
      checks++;
      if (o_core_data_val !== 1'b1 || o_core_data !== q[0] || o_net_en !== 1'b1) begin
        errors++; $display("FAIL simul[%0d]: got val=%b data=%h net_en=%b expected val=1 data=%h net_en=1",
                           cyc, o_core_data_val, o_core_data, o_net_en, q[0]);
      end
      tick();
      void'(q.pop_front());
    end
    i_net_data_val = 1'b0;
    i_net_data     = '0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_core_data_val !== 1'b1 || o_core_data !== q[0]) begin
        errors++; $display("FAIL simul_drain[%0d]: got val=%b data=%h expected val=1 data=%h", k, o_core_data_val, o_core_data, q[0]);
      end
      tick();
      void'(q.pop_front());
    end
    checks++; if (o_core_data_val !== 1'b0) begin errors++; $display("FAIL simul_empty: got %b expected 0", o_core_data_val); end
    idle_inputs();
  endtask

  task automatic test_wrap;
    int sent = 0;
    int recv = 0;
    int net_en_drops = 0;
    logic acc_in, acc_out;
    idle_inputs();
    for (int cyc = 0; cyc < 40 && recv < 9; cyc++) begin
      i_core_en      = (cyc % 2 == 0);
      i_net_data_val = (cyc % 2 == 1) && (sent < 9);
      i_net_data     = 32'h200 + sent;
      if (o_net_en !== 1'b1) net_en_drops++;
      acc_in  = i_net_data_val && o_net_en;
      acc_out = o_core_data_val && i_core_en;
      if (acc_out) begin
        checks++;
        if (o_core_data !== 32'h200 + recv) begin
          errors++; $display("FAIL wrap_order[%0d]: got %h expected %h", recv, o_core_data, 32'h200 + recv);
        end
      end
      tick();
      if (acc_in) sent++;
      if (acc_out) recv++;
    end
    idle_inputs();
    checks++; if (recv !== 9) begin errors++; $display("FAIL wrap_count: got %0d expected 9", recv); end
    checks++; if (net_en_drops !== 0) begin errors++; $display("FAIL wrap_net_en: got %0d low cycles expected 0", net_en_drops); end
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      i_core_data     = 32'h300 + k;
      i_core_data_val = 1'b1;
      tick();
    end
    i_core_data_val = 1'b0;
    checks++; if (o_net_data_val !== 1'b1) begin errors++; $display("FAIL rmid_loaded: got %b expected 1", o_net_data_val); end
    reset_n = 1'b0;
    #1;
    checks++; if (o_net_data_val !== 1'b0) begin errors++; $display("FAIL rmid_val: got %b expected 0", o_net_data_val); end
    checks++; if (o_core_en !== 1'b1) begin errors++; $display("FAIL rmid_core_en: got %b expected 1", o_core_en); end
    checks++; if (o_net_data !== 32'h0) begin errors++; $display("FAIL rmid_data: got %h expected 0", o_net_data); end
    checks++; if (o_tx_count !== 32'h0 || o_rx_count !== 32'h0) begin errors++; $display("FAIL rmid_counts: got %0d/%0d expected 0/0", o_tx_count, o_rx_count); end
    #1;
    reset_n = 1'b1;
    i_net_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (o_net_data_val) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rmid_discarded: got %0d packets expected 0", seen); end
    idle_inputs();
  endtask

  task automatic test_stats;
    logic [31:0] exp_tx_mid, exp_rx_mid, exp_tx, exp_rx;
`ifdef NODE_INTERFACE_STATS_EN
    exp_tx_mid = 32'd3; exp_rx_mid = 32'd3; exp_tx = 32'd7; exp_rx = 32'd5;
`else
    exp_tx_mid = 32'd0; exp_rx_mid = 32'd0; exp_tx = 32'd0; exp_rx = 32'd0;
`endif
    idle_inputs();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    tick();
    for (int cyc = 0; cyc < 12; cyc++) begin
      i_net_en        = 1'b1;
      i_core_en       = 1'b1;
      i_core_data_val = (cyc < 7);
      i_core_data     = 32'h400 + cyc;
      i_net_data_val  = (cyc < 5);
      i_net_data      = 32'h500 + cyc;
      if (cyc == 4) begin
        checks++; if (o_tx_count !== exp_tx_mid) begin errors++; $display("FAIL stats_tx_mid: got %0d expected %0d", o_tx_count, exp_tx_mid); end
        checks++; if (o_rx_count !== exp_rx_mid) begin errors++; $display("FAIL stats_rx_mid: got %0d expected %0d", o_rx_count, exp_rx_mid); end
        checks++; if (o_net_en !== 1'b1 || o_core_en !== 1'b1) begin errors++; $display("FAIL stats_independent: got %b/%b expected 1/1", o_net_en, o_core_en); end
      end
      tick();
    end
    idle_inputs();
    checks++; if (o_tx_count !== exp_tx) begin errors++; $display("FAIL stats_tx: got %0d expected %0d", o_tx_count, exp_tx); end
    checks++; if (o_rx_count !== exp_rx) begin errors++; $display("FAIL stats_rx: got %0d expected %0d", o_rx_count, exp_rx); end
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_latency();
    test_tx_fill();
    test_simul_push_pop();
    test_wrap();
    test_reset_mid();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
